// File: rtl/flash_byte_reader.sv
// Byte-wide 8052 read front end over the on-chip flash Avalon-MM data port with a one-line burst buffer.
// Optional fill timeout with sticky rd_error is enabled by defining FLASH_RD_TIMEOUT_EN.
module flash_byte_reader #(
  parameter int BURST_LEN      = 8,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [20:0] cpu_addr,
  input  logic        cpu_rd,
  input  logic        flush,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_rvalid,
  output logic        cpu_busy,
  output logic        rd_error,
  output logic [18:0] avmm_data_addr,
  output logic        avmm_data_read,
  output logic [3:0]  avmm_data_burstcount,
  input  logic [31:0] avmm_data_readdata,
  input  logic        avmm_data_waitrequest,
  input  logic        avmm_data_readdatavalid
);

  localparam int          L         = $clog2(BURST_LEN);
  localparam int          IDX_W     = (L > 0) ? L : 1;
  localparam logic [18:0] BEAT_MASK = 19'(BURST_LEN - 1);
  localparam logic [18:0] BASE_MASK = ~BEAT_MASK;

  if (BURST_LEN < 1 || BURST_LEN > 8 || (BURST_LEN & (BURST_LEN - 1)) != 0 || TIMEOUT_CYCLES < 1)
  begin : g_bad_param
    $error("flash_byte_reader: BURST_LEN must be a power of two in 1..8 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {IDLE, REQ, COLLECT, RESP} state_t;

  state_t      state;
  logic [31:0] line_mem [BURST_LEN];
  logic        line_valid;
  logic [18:0] line_base;
  logic [20:0] req_addr;
  logic [3:0]  beat_cnt;
  logic        flush_seen;
  logic        tmo_hit;
  logic [18:0] cpu_base;
  logic        hit;
  logic        last_beat;

  function automatic logic [IDX_W-1:0] beat_of(input logic [20:0] a);
    return IDX_W'(a[20:2] & BEAT_MASK);
  endfunction

  function automatic logic [7:0] lane_of(input logic [31:0] w, input logic [1:0] lane);
    return w[8*lane +: 8];
  endfunction

  assign cpu_base  = cpu_addr[20:2] & BASE_MASK;
  // A flush in the same cycle as a read must force a miss, so it masks the hit directly.
  assign hit       = line_valid && !flush && (line_base == cpu_base);
  assign last_beat = (beat_cnt == 4'(BURST_LEN - 1));

  // NOTE: the line storage carries no reset; line_valid alone decides whether its contents mean anything.
  always_ff @(posedge clock) begin
    if (state == COLLECT && avmm_data_readdatavalid && !tmo_hit)
      line_mem[beat_cnt[IDX_W-1:0]] <= avmm_data_readdata;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state                <= IDLE;
      line_valid           <= 1'b0;
      line_base            <= '0;
      req_addr             <= '0;
      beat_cnt             <= '0;
      flush_seen           <= 1'b0;
      cpu_rdata            <= '0;
      cpu_rvalid           <= 1'b0;
      cpu_busy             <= 1'b0;
      avmm_data_addr       <= '0;
      avmm_data_read       <= 1'b0;
      avmm_data_burstcount <= '0;
    end else begin
      cpu_rvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (flush) line_valid <= 1'b0;
          if (cpu_rd) begin
            if (hit) begin
              cpu_rvalid <= 1'b1;
              cpu_rdata  <= lane_of(line_mem[beat_of(cpu_addr)], cpu_addr[1:0]);
            end else begin
              req_addr             <= cpu_addr;
              cpu_busy             <= 1'b1;
              line_valid           <= 1'b0;
              flush_seen           <= 1'b0;
              beat_cnt             <= '0;
              avmm_data_addr       <= cpu_base;
              avmm_data_read       <= 1'b1;
              avmm_data_burstcount <= 4'(BURST_LEN);
              state                <= REQ;
            end
          end
        end
        REQ: begin
          if (!avmm_data_waitrequest) begin
            avmm_data_read       <= 1'b0;
            avmm_data_burstcount <= '0;
            state                <= COLLECT;
          end
        end
        COLLECT: begin
          if (avmm_data_readdatavalid) begin
            beat_cnt <= beat_cnt + 4'd1;
            if (last_beat) begin
              line_base  <= req_addr[20:2] & BASE_MASK;
              line_valid <= !(flush_seen || flush);
              state      <= RESP;
            end
          end
        end
        RESP: begin
          cpu_rvalid <= 1'b1;
          cpu_rdata  <= lane_of(line_mem[beat_of(req_addr)], req_addr[1:0]);
          cpu_busy   <= 1'b0;
          if (flush) line_valid <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if ((state == REQ || state == COLLECT) && flush) flush_seen <= 1'b1;

      // An expired fill overrides whatever the state machine chose this cycle.
      if (tmo_hit) begin
        avmm_data_read       <= 1'b0;
        avmm_data_burstcount <= '0;
        line_valid           <= 1'b0;
        cpu_rvalid           <= 1'b1;
        cpu_rdata            <= 8'hFF;
        cpu_busy             <= 1'b0;
        state                <= IDLE;
      end
    end
  end

`ifdef FLASH_RD_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_cnt;
  logic             rd_error_q;

  assign tmo_hit  = (state == REQ || state == COLLECT) && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
  assign rd_error = rd_error_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      tmo_cnt    <= '0;
      rd_error_q <= 1'b0;
    end else begin
      if (state == REQ || state == COLLECT) tmo_cnt <= tmo_cnt + 1'b1;
      else                                  tmo_cnt <= '0;
      if (tmo_hit) rd_error_q <= 1'b1;
    end
  end
`else
  assign tmo_hit  = 1'b0;
  assign rd_error = 1'b0;
`endif

endmodule

// File: tb/tb_flash_byte_reader.sv
// Scoreboard bench for flash_byte_reader: an Avalon burst slave model serves flash words,
// a monitor pops expected bytes on every cpu_rvalid. Timeout case needs FLASH_RD_TIMEOUT_EN.
module tb_flash_byte_reader;

`ifdef FLASH_RD_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 1023;
`endif

  logic        clock = 1'b0;
  logic        reset_n;
  logic [20:0] cpu_addr;
  logic        cpu_rd;
  logic        flush;
  logic [7:0]  cpu_rdata;
  logic        cpu_rvalid;
  logic        cpu_busy;
  logic        rd_error;
  logic [18:0] avmm_data_addr;
  logic        avmm_data_read;
  logic [3:0]  avmm_data_burstcount;
  logic [31:0] avmm_data_readdata;
  logic        avmm_data_waitrequest;
  logic        avmm_data_readdatavalid;

  always #5 clock = ~clock;

  flash_byte_reader #(.BURST_LEN(8), .TIMEOUT_CYCLES(TMO)) dut (
    .clock                   (clock),
    .reset_n                 (reset_n),
    .cpu_addr                (cpu_addr),
    .cpu_rd                  (cpu_rd),
    .flush                   (flush),
    .cpu_rdata               (cpu_rdata),
    .cpu_rvalid              (cpu_rvalid),
    .cpu_busy                (cpu_busy),
    .rd_error                (rd_error),
    .avmm_data_addr          (avmm_data_addr),
    .avmm_data_read          (avmm_data_read),
    .avmm_data_burstcount    (avmm_data_burstcount),
    .avmm_data_readdata      (avmm_data_readdata),
    .avmm_data_waitrequest   (avmm_data_waitrequest),
    .avmm_data_readdatavalid (avmm_data_readdatavalid)
  );

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  int resp_count = 0;

  // Slave model configuration and observation.
  int          wait_cfg     = 0;
  int          gap_cfg      = 0;
  bit          hold_forever = 1'b0;
  int          cmd_count    = 0;
  int          beats_sent   = 0;
  int          read_hi      = 0;
  logic [18:0] cmd_addr     = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic fail(input string name, input logic [63:0] act);
    checks++;
    failures++;
    $display("FAIL %s: actual=0x%0h required=none", name, act);
  endtask

  // Flash contents: byte at address a = ((a+1)*0x11 mod 256) xor a[15:8].
  function automatic logic [7:0] flash_byte(input logic [20:0] a);
    logic [31:0] s;
    s = 32'(a) + 32'd1;
    return 8'(s * 32'd17) ^ a[15:8];
  endfunction

  function automatic logic [31:0] flash_word(input logic [18:0] w);
    return {flash_byte({w, 2'd3}), flash_byte({w, 2'd2}), flash_byte({w, 2'd1}), flash_byte({w, 2'd0})};
  endfunction

  task automatic check_all_zero(input string name);
    check(name, {cpu_rdata, cpu_rvalid, cpu_busy, rd_error, avmm_data_addr, avmm_data_read,
                 avmm_data_burstcount}, 64'd0);
  endtask

  task automatic issue(input logic [20:0] a, input bit push, input logic [7:0] e);
    int n = 0;
    @(negedge clock);
    while (cpu_busy && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) fail("busy_never_cleared", 64'(cpu_busy));
    cpu_addr = a;
    cpu_rd   = 1'b1;
    if (push) exp_q.push_back(e);
    @(negedge clock);
    cpu_rd = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while ((cpu_busy || exp_q.size() != 0) && n < budget);
    if (n >= budget) fail("idle_budget_expired", 64'(exp_q.size()));
    @(negedge clock);
  endtask

  initial begin : slave
    bit          in_burst = 1'b0;
    int          stall    = 0;
    int          gap      = 0;
    logic [18:0] base     = '0;
    avmm_data_waitrequest   = 1'b0;
    avmm_data_readdatavalid = 1'b0;
    avmm_data_readdata      = '0;
    forever begin
      @(negedge clock);
      avmm_data_readdatavalid = 1'b0;
      if (!reset_n) begin
        in_burst              = 1'b0;
        stall                 = 0;
        avmm_data_waitrequest = 1'b0;
      end else if (in_burst) begin
        if (avmm_data_read) fail("extra_cmd_during_burst", 64'(avmm_data_addr));
        if (gap > 0) gap--;
        else begin
          avmm_data_readdata      = flash_word(base + 19'(beats_sent));
          avmm_data_readdatavalid = 1'b1;
          beats_sent++;
          gap = gap_cfg;
          if (beats_sent == 8) in_burst = 1'b0;
        end
      end else if (avmm_data_read) begin
        read_hi++;
        if (stall == 0) base = avmm_data_addr;
        else begin
          check("stall_addr_stable", 64'(avmm_data_addr), 64'(base));
          check("stall_burstcount_stable", 64'(avmm_data_burstcount), 64'd8);
        end
        if (hold_forever || stall < wait_cfg) begin
          avmm_data_waitrequest = 1'b1;
          stall++;
        end else begin
          avmm_data_waitrequest = 1'b0;
          stall      = 0;
          cmd_count++;
          cmd_addr   = avmm_data_addr;
          check("cmd_burstcount", 64'(avmm_data_burstcount), 64'd8);
          in_burst   = 1'b1;
          beats_sent = 0;
          gap        = gap_cfg;
        end
      end else begin
        stall = 0;
      end
    end
  end

  initial begin : monitor
    logic [7:0] e;
    forever begin
      @(negedge clock);
      if (cpu_rvalid) begin
        resp_count++;
        if (exp_q.size() == 0) fail("unexpected_response", 64'(cpu_rdata));
        else begin
          e = exp_q.pop_front();
          check("rdata", 64'(cpu_rdata), 64'(e));
        end
        check("busy_low_at_rvalid", 64'(cpu_busy), 64'd0);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: actual=0x%0h required=none", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int c0;
    int r0;
    int lat;
    int n;
    cpu_addr = '0;
    cpu_rd   = 1'b0;
    flush    = 1'b0;
    reset_n  = 1'b0;
    repeat (3) @(negedge clock);
    check_all_zero("reset_outputs");
    reset_n = 1'b1;
    @(negedge clock);

    // 1: first miss at 0x00005 -> burst at word 0, byte 0x66, latency 1+0+8+1.
    c0 = cmd_count;
    issue(21'h00005, 1'b1, 8'h66);
    check("t1_busy_after_accept", 64'(cpu_busy), 64'd1);
    lat = 0;
    do begin
      @(negedge clock);
      lat++;
    end while (!cpu_rvalid && lat < 100);
    check("t1_latency", 64'(lat), 64'd10);
    check("t1_cmd_count", 64'(cmd_count - c0), 64'd1);
    check("t1_cmd_addr", 64'(cmd_addr), 64'h0);
    wait_idle(100);

    // 2: 32 back-to-back hits over the cached line.
    c0 = cmd_count;
    r0 = resp_count;
    for (int i = 0; i < 32; i++) begin
      cpu_addr = 21'(i);
      cpu_rd   = 1'b1;
      exp_q.push_back(flash_byte(21'(i)));
      @(negedge clock);
    end
    cpu_rd = 1'b0;
    repeat (2) @(negedge clock);
    check("t2_responses", 64'(resp_count - r0), 64'd32);
    check("t2_no_cmd", 64'(cmd_count - c0), 64'd0);

    // 3: 5-cycle stall plus 2-cycle gaps between beats; 0x4B -> byte 0x0C.
    wait_cfg = 5;
    gap_cfg  = 2;
    c0 = cmd_count;
    issue(21'h0004B, 1'b1, 8'h0C);
    wait_idle(200);
    check("t3_cmd_count", 64'(cmd_count - c0), 64'd1);
    check("t3_cmd_addr", 64'(cmd_addr), 64'h10);
    wait_cfg = 0;

    // 4: flush mid-fill; reread refetches, then a hit, then flush+read forces a miss.
    gap_cfg = 3;
    c0 = cmd_count;
    issue(21'h00123, 1'b1, 8'h65);
    repeat (6) @(negedge clock);
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    wait_idle(200);
    issue(21'h00123, 1'b1, 8'h65);
    wait_idle(200);
    check("t4_refetch", 64'(cmd_count - c0), 64'd2);
    check("t4_cmd_addr", 64'(cmd_addr), 64'h48);
    issue(21'h00122, 1'b1, 8'h52);
    wait_idle(50);
    check("t4_hit_no_cmd", 64'(cmd_count - c0), 64'd2);
    cpu_addr = 21'h00121;
    cpu_rd   = 1'b1;
    flush    = 1'b1;
    exp_q.push_back(8'h43);
    @(negedge clock);
    cpu_rd = 1'b0;
    flush  = 1'b0;
    wait_idle(200);
    check("t4_flush_with_read_misses", 64'(cmd_count - c0), 64'd3);

    // 5: reset during beat 3 abandons the read; next read at 0x100 -> word 0x40, byte 0x10.
    gap_cfg = 1;
    c0 = cmd_count;
    issue(21'h00200, 1'b0, 8'h00);
    n = 0;
    while (!(cmd_count == c0 + 1 && beats_sent == 3) && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) fail("t5_beat3_never_seen", 64'(beats_sent));
    reset_n = 1'b0;
    @(negedge clock);
    check_all_zero("t5_reset_outputs");
    @(negedge clock);
    check_all_zero("t5_reset_outputs_hold");
    reset_n = 1'b1;
    gap_cfg = 0;
    repeat (20) @(negedge clock);
    issue(21'h00100, 1'b1, 8'h10);
    wait_idle(100);
    check("t5_cmd_count", 64'(cmd_count - c0), 64'd2);
    check("t5_cmd_addr", 64'(cmd_addr), 64'h40);

`ifdef FLASH_RD_TIMEOUT_EN
    // 6: waitrequest stuck -> abort after 16 cycles, 0xFF, sticky rd_error, retry refetches.
    hold_forever = 1'b1;
    read_hi = 0;
    c0 = cmd_count;
    issue(21'h00300, 1'b1, 8'hFF);
    wait_idle(100);
    check("t6_rd_error", 64'(rd_error), 64'd1);
    check("t6_read_cycles", 64'(read_hi), 64'd16);
    check("t6_no_cmd", 64'(cmd_count - c0), 64'd0);
    check("t6_read_dropped", 64'(avmm_data_read), 64'd0);
    hold_forever = 1'b0;
    issue(21'h00300, 1'b1, 8'h12);
    wait_idle(100);
    check("t6_retry_cmd", 64'(cmd_count - c0), 64'd1);
    check("t6_rd_error_sticky", 64'(rd_error), 64'd1);
`else
    check("rd_error_tied_low", 64'(rd_error), 64'd0);
`endif

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
